// File: rtl/core_sequencer.sv
// core_sequencer
//   Multi-cycle control FSM for the RV32I core. It steps each instruction
//   through FETCH, DECODE, EXECUTE, MEM and WB, drives the memory request
//   handshakes and the write strobes, and halts on an illegal opcode or a
//   memory timeout.
//
// Parameters
//   DWIDTH  : width of the performance counters
//   TIMEOUT : max wait cycles for imem/dmem ready before an error halt (0 = off)
//
// Build option
//   PERF_COUNTERS_EN : when defined, retired_o/cycles_o are live counters;
//                      when undefined they are tied to zero and no flops exist.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   opcode_i           : opcode from the decode stage
//   br_taken_i         : branch comparison result, valid in EXECUTE
//   imem_ready_i       : instruction memory returns data this cycle
//   dmem_ready_i       : data memory completes the access this cycle
//   imem_req_o         : instruction fetch request
//   insn_we_o          : latch fetched instruction into the IR
//   dmem_req_o         : data memory request
//   dmem_we_o          : data memory write (store)
//   rf_we_o            : register file write enable
//   pc_we_o            : PC update strobe
//   pc_sel_o           : PC source (0 pc+4, 1 pc+imm, 2 (rs1+imm)&~1)
//   state_o            : current state encoding
//   halted_o, err_o    : sticky halt / sticky timeout error
//   retired_o, cycles_o: performance counters
module core_sequencer #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        opcode_i,
  input  logic              br_taken_i,
  input  logic              imem_ready_i,
  input  logic              dmem_ready_i,
  output logic              imem_req_o,
  output logic              insn_we_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic              rf_we_o,
  output logic              pc_we_o,
  output logic [1:0]        pc_sel_o,
  output logic [2:0]        state_o,
  output logic              halted_o,
  output logic              err_o,
  output logic [DWIDTH-1:0] retired_o,
  output logic [DWIDTH-1:0] cycles_o
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Wait counter only ever needs to reach TIMEOUT-1.
  localparam int unsigned TLAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam int unsigned TW    = (TLAST < 2) ? 1 : $clog2(TLAST + 1);

  state_t        state;
  state_t        nxt;
  logic [6:0]    opcode_q;
  logic [TW-1:0] tmo_cnt;
  logic          halted_q;
  logic          err_q;

  logic          imem_req;
  logic          insn_we;
  logic          dmem_req;
  logic          dmem_we;
  logic          rf_we;
  logic          pc_we;
  logic [1:0]    pc_sel;
  logic          legal_op;
  logic          tmo_expire;

  always_comb begin
    case (opcode_i)
      OP_RTYPE, OP_IMM, OP_LOAD, OP_JALR, OP_STORE,
      OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: legal_op = 1'b1;
      default:                             legal_op = 1'b0;
    endcase
  end

  assign tmo_expire = (TIMEOUT != 0) && (tmo_cnt == TW'(TLAST));

  // Next state and strobes. Ready takes priority over expiry, so a response
  // in the last allowed cycle still completes normally.
  always_comb begin
    nxt      = state;
    imem_req = 1'b0;
    insn_we  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready_i) begin
          insn_we = 1'b1;
          nxt     = S_DECODE;
        end else if (tmo_expire) begin
          nxt = S_HALT;
        end
      end
      S_DECODE: begin
        nxt = legal_op ? S_EXECUTE : S_HALT;
      end
      S_EXECUTE: begin
        if (opcode_q == OP_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = br_taken_i ? 2'd1 : 2'd0;
          nxt    = S_FETCH;
        end else if (opcode_q == OP_LOAD || opcode_q == OP_STORE) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode_q == OP_STORE);
        if (dmem_ready_i) begin
          if (opcode_q == OP_STORE) begin
            pc_we = 1'b1;
            nxt   = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (tmo_expire) begin
          nxt = S_HALT;
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        if (opcode_q == OP_JAL)       pc_sel = 2'd1;
        else if (opcode_q == OP_JALR) pc_sel = 2'd2;
        else                          pc_sel = 2'd0;
        nxt = S_FETCH;
      end
      default: begin
        nxt = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      opcode_q <= '0;
      tmo_cnt  <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) begin
        opcode_q <= opcode_i;
      end
      if (nxt == S_HALT && state != S_HALT) begin
        halted_q <= 1'b1;
        // Only the two wait states can reach HALT by expiry.
        if (state == S_FETCH || state == S_MEM) begin
          err_q <= 1'b1;
        end
      end
      // Any state change clears the count, which covers entry to FETCH/MEM.
      if (nxt != state) begin
        tmo_cnt <= '0;
      end else if ((state == S_FETCH || state == S_MEM) && TIMEOUT != 0) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // Everything is forced low while reset is held, including registered state.
  assign imem_req_o = imem_req & ~rst;
  assign insn_we_o  = insn_we  & ~rst;
  assign dmem_req_o = dmem_req & ~rst;
  assign dmem_we_o  = dmem_we  & ~rst;
  assign rf_we_o    = rf_we    & ~rst;
  assign pc_we_o    = pc_we    & ~rst;
  assign pc_sel_o   = rst ? 2'd0 : pc_sel;
  assign state_o    = rst ? 3'd0 : state;
  assign halted_o   = halted_q & ~rst;
  assign err_o      = err_q    & ~rst;

`ifdef PERF_COUNTERS_EN
  logic [DWIDTH-1:0] retired_q;
  logic [DWIDTH-1:0] cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      if (state != S_HALT) cycles_q <= cycles_q + 1'b1;
      if (pc_we)           retired_q <= retired_q + 1'b1;
    end
  end

  assign retired_o = rst ? '0 : retired_q;
  assign cycles_o  = rst ? '0 : cycles_q;
`else
  assign retired_o = '0;
  assign cycles_o  = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Testbench for core_sequencer. Each instruction is expanded from its class
// (fetch wait, decode, execute, optional memory wait, optional writeback) into
// the per-cycle outputs the sequencer must show, and every cycle is compared.
module tb_core_sequencer;

  localparam int unsigned DW  = 8;
  localparam int unsigned TMO = 16;

  localparam logic [2:0] ST_F = 3'd0;
  localparam logic [2:0] ST_D = 3'd1;
  localparam logic [2:0] ST_E = 3'd2;
  localparam logic [2:0] ST_M = 3'd3;
  localparam logic [2:0] ST_W = 3'd4;
  localparam logic [2:0] ST_H = 3'd5;

  localparam logic [6:0] ADDI  = 7'b0010011;
  localparam logic [6:0] RTYPE = 7'b0110011;
  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] BEQ   = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] LEGAL [9] = '{RTYPE, ADDI, LW, JALR, SW, BEQ, LUI, AUIPC, JAL};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    opcode_i = '0;
  logic          br_taken_i = 1'b0;
  logic          imem_ready_i = 1'b0;
  logic          dmem_ready_i = 1'b0;
  logic          imem_req_o, insn_we_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o;
  logic [1:0]    pc_sel_o;
  logic [2:0]    state_o;
  logic          halted_o, err_o;
  logic [DW-1:0] retired_o, cycles_o;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] m_ret = '0;
  logic [DW-1:0] m_cyc = '0;
  logic          m_halted = 1'b0;
  logic          m_err = 1'b0;

  core_sequencer #(.DWIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode_i(opcode_i), .br_taken_i(br_taken_i),
    .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
    .imem_req_o(imem_req_o), .insn_we_o(insn_we_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .rf_we_o(rf_we_o), .pc_we_o(pc_we_o),
    .pc_sel_o(pc_sel_o), .state_o(state_o), .halted_o(halted_o), .err_o(err_o),
    .retired_o(retired_o), .cycles_o(cycles_o)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] r7();
    return 7'($urandom);
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    foreach (LEGAL[i]) if (LEGAL[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_cnt(input logic [DW-1:0] v);
`ifdef PERF_COUNTERS_EN
    return v;
`else
    return '0 & v;
`endif
  endfunction

  // One clock: apply inputs, check outputs mid-cycle, then advance.
  // stb = {imem_req, insn_we, dmem_req, dmem_we, rf_we, pc_we}
  task automatic cyc(input string tag, input logic [2:0] st, input logic [5:0] stb,
                     input logic [1:0] sel, input logic ir, input logic dr,
                     input logic [6:0] op, input logic br);
    logic [12:0] exp_v, got_v;
    imem_ready_i = ir;
    dmem_ready_i = dr;
    opcode_i     = op;
    br_taken_i   = br;
    #1;
    exp_v = {st, stb, sel, m_halted, m_err};
    got_v = {state_o, imem_req_o, insn_we_o, dmem_req_o, dmem_we_o, rf_we_o,
             pc_we_o, pc_sel_o, halted_o, err_o};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s outputs @%0t: got %b required %b", tag, $time, got_v, exp_v);
    end
    vectors++;
    if ({retired_o, cycles_o} !== {exp_cnt(m_ret), exp_cnt(m_cyc)}) begin
      miscompares++;
      $display("FAIL %s counters @%0t: got ret=%0d cyc=%0d required ret=%0d cyc=%0d",
               tag, $time, retired_o, cycles_o, exp_cnt(m_ret), exp_cnt(m_cyc));
    end
    @(posedge clk);
    #2;
    if (st != ST_H) m_cyc++;
    if (stb[0])     m_ret++;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    imem_ready_i = rb();
    dmem_ready_i = rb();
    opcode_i = r7();
    br_taken_i = rb();
    #1;
    vectors++;
    if ({state_o, imem_req_o, insn_we_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o,
         pc_sel_o, halted_o, err_o, retired_o, cycles_o} !== '0) begin
      miscompares++;
      $display("FAIL %s reset outputs: got st=%0d ireq=%b dreq=%b pcwe=%b halt=%b err=%b ret=%0d cyc=%0d required all zero",
               tag, state_o, imem_req_o, dmem_req_o, pc_we_o, halted_o, err_o, retired_o, cycles_o);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    m_ret = '0;
    m_cyc = '0;
    m_halted = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic halt_cycles(input string tag, input int n);
    for (int k = 0; k < n; k++) cyc(tag, ST_H, 6'b0, 2'd0, rb(), rb(), r7(), rb());
  endtask

  // Expands one instruction into its cycle sequence. idly/ddly are the number
  // of cycles ready stays low; >= TMO means it never arrives in time.
  task automatic run_insn(input string tag, input logic [6:0] op, input int idly,
                          input int ddly, input logic br);
    logic rdy;
    logic st;
    for (int i = 0; i < TMO; i++) begin
      rdy = (i == idly);
      cyc(tag, ST_F, {1'b1, rdy, 4'b0}, 2'd0, rdy, rb(), r7(), rb());
      if (rdy) break;
    end
    if (idly >= TMO) begin
      m_halted = 1'b1;
      m_err = 1'b1;
      halt_cycles(tag, 3);
      return;
    end
    cyc(tag, ST_D, 6'b0, 2'd0, rb(), rb(), op, rb());
    if (!is_legal(op)) begin
      m_halted = 1'b1;
      halt_cycles(tag, 3);
      return;
    end
    if (op == BEQ) begin
      cyc(tag, ST_E, 6'b000001, {1'b0, br}, rb(), rb(), r7(), br);
      return;
    end
    cyc(tag, ST_E, 6'b0, 2'd0, rb(), rb(), r7(), rb());
    if (op == LW || op == SW) begin
      st = (op == SW);
      for (int i = 0; i < TMO; i++) begin
        rdy = (i == ddly);
        cyc(tag, ST_M, {2'b00, 1'b1, st, 1'b0, rdy & st}, 2'd0, rb(), rdy, r7(), rb());
        if (rdy) break;
      end
      if (ddly >= TMO) begin
        m_halted = 1'b1;
        m_err = 1'b1;
        halt_cycles(tag, 3);
        return;
      end
      if (st) return;
    end
    cyc(tag, ST_W, 6'b000011, (op == JAL) ? 2'd1 : (op == JALR) ? 2'd2 : 2'd0,
        rb(), rb(), r7(), rb());
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_alu();
    run_insn("addi", ADDI, 0, 0, 1'b0);
    run_insn("rtype", RTYPE, 2, 0, 1'b1);
    run_insn("lui", LUI, 0, 0, 1'b0);
    run_insn("auipc", AUIPC, 1, 0, 1'b0);
  endtask

  task automatic test_branch();
    run_insn("beq_taken", BEQ, 0, 0, 1'b1);
    run_insn("beq_not_taken", BEQ, 0, 0, 1'b0);
  endtask

  task automatic test_load_store();
    run_insn("lw_delay3", LW, 0, 3, 1'b0);
    run_insn("sw_delay3", SW, 0, 3, 1'b0);
    run_insn("sw_fast", SW, 1, 0, 1'b0);
  endtask

  task automatic test_jumps();
    run_insn("jalr", JALR, 0, 0, 1'b0);
    run_insn("jal", JAL, 0, 0, 1'b1);
  endtask

  task automatic test_illegal();
    run_insn("illegal_0", 7'b0000000, 0, 0, 1'b0);
    do_reset("illegal_reset");
    run_insn("after_illegal", ADDI, 0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_insn("imem_timeout", ADDI, TMO, 0, 1'b0);
    do_reset("imem_timeout_reset");
    run_insn("imem_last_cycle", ADDI, TMO - 1, 0, 1'b0);
    run_insn("dmem_timeout", LW, 0, TMO, 1'b0);
    do_reset("dmem_timeout_reset");
    run_insn("dmem_last_cycle", SW, 0, TMO - 1, 1'b0);
  endtask

  task automatic test_reset_mid_mem();
    cyc("rst_mem", ST_F, 6'b110000, 2'd0, 1'b1, 1'b0, r7(), 1'b0);
    cyc("rst_mem", ST_D, 6'b0, 2'd0, 1'b0, 1'b0, LW, 1'b0);
    cyc("rst_mem", ST_E, 6'b0, 2'd0, 1'b0, 1'b0, r7(), 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("rst_mem", ST_M, 6'b001000, 2'd0, rb(), 1'b0, r7(), rb());
    do_reset("rst_mem_reset");
    run_insn("after_rst_mem", SW, 0, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [6:0] op;
    int idly, ddly;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 19) == 0) op = r7();
      else op = LEGAL[$urandom_range(0, 8)];
      idly = ($urandom_range(0, 24) == 0) ? TMO - 1 + int'($urandom_range(0, 1))
                                          : int'($urandom_range(0, 3));
      ddly = ($urandom_range(0, 24) == 0) ? TMO - 1 + int'($urandom_range(0, 1))
                                          : int'($urandom_range(0, 3));
      run_insn("random", op, idly, ddly, rb());
      if (m_halted) do_reset("random_reset");
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_load_store();
    test_jumps();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM that sequences the fetch, decode, execute, memory and writeback phases of the RV32I core around the decode stage.
- Takes the decoded opcode and the branch outcome as inputs.
- Drives the instruction and data memory request handshakes, the instruction-register, PC and register-file write strobes, and the PC source select.
- Halts on an illegal opcode or on a memory timeout.

Parameters:
DWIDTH, 32, width of the performance counters.
TIMEOUT, 16, maximum wait cycles for imem/dmem ready before error halt; 0 disables the timeout.

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
opcode_i  input  7  opcode from decode stage (opcode_o)
br_taken_i  input  1  branch comparison result, valid in EXECUTE
imem_ready_i  input  1  instruction memory returns data this cycle
dmem_ready_i  input  1  data memory completes the access this cycle
imem_req_o  output  1  instruction fetch request
insn_we_o  output  1  latch fetched instruction into the instruction register
dmem_req_o  output  1  data memory request
dmem_we_o  output  1  data memory write (store)
rf_we_o  output  1  register file write enable
pc_we_o  output  1  PC update strobe
pc_sel_o  output  2  PC source: 0 = pc+4, 1 = pc+imm (branch taken/JAL), 2 = (rs1+imm)&~1 (JALR)
state_o  output  3  current state encoding
halted_o  output  1  sticky halt
err_o  output  1  sticky timeout error
retired_o  output  DWIDTH  retired instruction count
cycles_o  output  DWIDTH  cycle count

Behaviour:
- Reset: one clock, synchronous, active-high. While rst=1 all outputs are 0 (strobes gated). State goes to FETCH; opcode_q, timeout counter, halted_o, err_o and counters clear. rst mid-operation aborts any pending request; FETCH is entered on the first cycle after rst deasserts.
- States and encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5.
- Strobes are Moore/Mealy-decoded from the state register and are never asserted in HALT.
- FETCH:
  - imem_req_o=1 every cycle.
  - When imem_ready_i=1: insn_we_o=1 in that same cycle; next state DECODE.
- DECODE:
  - Register opcode_i into opcode_q.
  - Legal opcodes: 0110011, 0010011, 0000011, 1100111, 0100011, 1100011, 0110111, 0010111, 1101111. Legal -> EXECUTE.
  - Any other opcode -> HALT with halted_o=1; pc_we_o is not asserted.
- EXECUTE (uses opcode_q):
  - Branch: pc_we_o=1, pc_sel_o=br_taken_i?1:0; next FETCH.
  - Load or store: next MEM.
  - All others: next WB.
- MEM:
  - dmem_req_o=1; dmem_we_o=1 for store.
  - On dmem_ready_i: store -> pc_we_o=1, pc_sel_o=0, next FETCH; load -> next WB.
- WB:
  - rf_we_o=1 and pc_we_o=1 in one cycle; next FETCH.
  - pc_sel_o=1 for JAL, 2 for JALR, 0 otherwise.
- Latency per instruction, with ready in the first request cycle: branch 3 cycles, store 4, load 5, ALU/LUI/AUIPC/JAL/JALR 4.
- Timeout counter:
  - Clears on entry to FETCH and MEM; increments each cycle spent waiting without ready.
  - If TIMEOUT!=0 and the count reaches TIMEOUT-1 with ready still low, the next state is HALT and err_o=1, halted_o=1.
  - Ready arriving in the expiry cycle wins: the normal transition occurs and no error is raised.
- HALT is terminal until rst. halted_o and err_o are sticky.
- pc_sel_o is 0 in every cycle where pc_we_o=0.

Optional Feature:
PERF_COUNTERS_EN:
- Defined:
  - cycles_o increments every non-reset cycle and stops incrementing in HALT.
  - retired_o increments on every pc_we_o pulse.
  - Both wrap modulo 2^DWIDTH and clear on rst.
- Undefined: retired_o and cycles_o are tied to 0 and no counter flops are synthesized.

Test Plan:
- ADDI (0010011), imem_ready_i=1 immediately -> states 0,1,2,4,0; rf_we_o=1 and pc_we_o=1 with pc_sel_o=0 in cycle 4; retired_o=1 (macro defined).
- BEQ (1100011), br_taken_i=1 in EXECUTE -> pc_we_o=1, pc_sel_o=1 in cycle 3; rf_we_o never asserted; FETCH in cycle 4.
- LW (0000011) with dmem_ready_i delayed 3 cycles -> dmem_req_o high 4 cycles, dmem_we_o=0, then WB with rf_we_o=1; SW (0100011) -> dmem_we_o=1 and pc_we_o on the ready cycle, no WB.
- JALR (1100111) -> WB asserts rf_we_o=1, pc_we_o=1, pc_sel_o=2.
- Opcode 0000000 in DECODE -> state HALT(5), halted_o=1, err_o=0, no strobes afterwards; rst=1 for one cycle -> FETCH, halted_o=0.
- TIMEOUT=16, imem_ready_i held 0 -> HALT after 16 FETCH cycles with err_o=1; repeat with ready on cycle 16 -> DECODE, err_o=0; rst asserted during MEM wait -> dmem_req_o drops in the reset cycle, then FETCH.
